// File: rtl/pipelined_butterfly.sv
// Four-stage modular butterfly for the NTT/INTT datapath: Cooley-Tukey NTT,
// Gentleman-Sande INTT with exact halving, bypass and idle, behind a valid/ready handshake.
module pipelined_butterfly #(
  parameter int WIDTH = 16,
  parameter int Q     = 3329,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = 2 * WIDTH;
  localparam int K  = PW;
  localparam logic [WIDTH-1:0] QW  = WIDTH'(Q);
  localparam logic [PW-1:0]    QP  = PW'(Q);
  localparam logic [K:0]       M_C = (K+1)'({1'b1, {K{1'b0}}} / (K+1)'(Q));

  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_INTT = 2'b01;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + {1'b0, QW} - {1'b0, y};
    return s[WIDTH-1:0];
  endfunction

  // Exact division by two mod Q: odd values borrow one Q so the shift is lossless.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, QW}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  // Barrett estimate undershoots by at most 2Q, so two subtractions fully reduce.
  function automatic logic [WIDTH-1:0] barrett(input logic [PW-1:0] p);
    logic [PW+K:0] prod;
    logic [PW-1:0] qe;
    logic [PW-1:0] r;
    prod = {{(K+1){1'b0}}, p} * {{PW{1'b0}}, M_C};
    qe   = PW'(prod >> K);
    r    = p - qe * QP;
    if (r >= QP) r = r - QP;
    if (r >= QP) r = r - QP;
    return r[WIDTH-1:0];
  endfunction

  logic             stall, advance;
  logic             vld_p1_q, vld_p2_q, vld_p3_q, out_valid_q;
  logic [WIDTH-1:0] a_p1_q, b_p1_q, w_p1_q;
  logic [1:0]       mode_p1_q, mode_p2_q, mode_p3_q;
  logic [TAG_W-1:0] tag_p1_q, tag_p2_q, tag_p3_q, out_tag_q;
  logic [WIDTH-1:0] diff_p1, sum_p1, m_p1;
  logic [PW-1:0]    prod_p2_q;
  logic [WIDTH-1:0] a_p2_q, b_p2_q, sum_p2_q;
  logic [WIDTH-1:0] t_p3_q, a_p3_q, b_p3_q, sum_p3_q;
  logic [WIDTH-1:0] c_d, d_d, c_q, d_q;
  logic [CNT_W-1:0] op_count_q;

  assign stall    = out_valid_q && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;

  assign diff_p1 = sub_mod(a_p1_q, b_p1_q);
  assign sum_p1  = add_mod(a_p1_q, b_p1_q);
  assign m_p1    = (mode_p1_q == MODE_INTT) ? diff_p1 : b_p1_q;

  always_comb begin
    c_d = a_p3_q;
    d_d = b_p3_q;
    case (mode_p3_q)
      MODE_NTT: begin
        c_d = add_mod(a_p3_q, t_p3_q);
        d_d = sub_mod(a_p3_q, t_p3_q);
      end
      MODE_INTT: begin
        c_d = half_mod(sum_p3_q);
        d_d = half_mod(t_p3_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      d_q         <= '0;
      out_tag_q   <= '0;
      op_count_q  <= '0;
    end else begin
      if (advance) begin
        vld_p1_q    <= in_valid && (mode != MODE_IDLE);
        vld_p2_q    <= vld_p1_q;
        vld_p3_q    <= vld_p2_q;
        out_valid_q <= vld_p3_q;
        c_q         <= c_d;
        d_q         <= d_d;
        out_tag_q   <= tag_p3_q;
      end
      if (out_valid_q && out_ready) op_count_q <= op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      // S1: operand capture
      a_p1_q    <= a;
      b_p1_q    <= b;
      w_p1_q    <= w;
      mode_p1_q <= mode;
      tag_p1_q  <= tag;
      // S2: twiddle product
      prod_p2_q <= {{WIDTH{1'b0}}, w_p1_q} * {{WIDTH{1'b0}}, m_p1};
      a_p2_q    <= a_p1_q;
      b_p2_q    <= b_p1_q;
      sum_p2_q  <= sum_p1;
      mode_p2_q <= mode_p1_q;
      tag_p2_q  <= tag_p1_q;
      // S3: Barrett reduction
      t_p3_q    <= barrett(prod_p2_q);
      a_p3_q    <= a_p2_q;
      b_p3_q    <= b_p2_q;
      sum_p3_q  <= sum_p2_q;
      mode_p3_q <= mode_p2_q;
      tag_p3_q  <= tag_p2_q;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign d         = d_q;
  assign out_tag   = out_tag_q;
  assign op_count  = op_count_q;

endmodule
